// File: rtl/fixed_act_pkg.sv
// Shared helpers for the fixed-point activation requantiser.
// This file holds the per-lane round and saturate functions, the shift and
// saturation-bound derivations, and the default-configuration constants.
// All arithmetic uses one wide signed type, so every caller can sign-extend
// into it and then truncate the result back to its own width.
package fixed_act_pkg;

  // Widest input word the helpers support. The extra top bit absorbs the
  // rounding carry.
  localparam int MAX_W = 64;

  typedef logic signed [MAX_W:0] wide_t;

  localparam wide_t ONE = wide_t'(1);

  // Constants for the default configuration (Q16.16 in, Q4.4 out).
  localparam int DEF_IN_W     = 32;
  localparam int DEF_IN_FRAC  = 16;
  localparam int DEF_OUT_W    = 8;
  localparam int DEF_OUT_FRAC = 4;

  // Number of fraction bits dropped between the input and output formats.
  function automatic int calc_shift(input int in_frac, input int out_frac);
    return in_frac - out_frac;
  endfunction

  // Largest value an out_w-bit signed word can hold.
  function automatic wide_t sat_max(input int out_w);
    return (ONE <<< (out_w - 1)) - ONE;
  endfunction

  // Smallest value an out_w-bit signed word can hold.
  function automatic wide_t sat_min(input int out_w);
    return -(ONE <<< (out_w - 1));
  endfunction

  localparam int    DEF_SHIFT   = calc_shift(DEF_IN_FRAC, DEF_OUT_FRAC);
  localparam wide_t DEF_SAT_MAX = sat_max(DEF_OUT_W);
  localparam wide_t DEF_SAT_MIN = sat_min(DEF_OUT_W);

  // Round half-up, then arithmetic-shift right by s.
  // When s is 0, the value passes through unrounded.
  function automatic wide_t round_lane(input wide_t x, input int s);
    if (s <= 0) begin
      return x;
    end
    return (x + (ONE <<< (s - 1))) >>> s;
  endfunction

  // Clamp x to the range of an out_w-bit signed word.
  function automatic wide_t sat_value(input wide_t x, input int out_w);
    if (x > sat_max(out_w)) begin
      return sat_max(out_w);
    end
    if (x < sat_min(out_w)) begin
      return sat_min(out_w);
    end
    return x;
  endfunction

  // Returns 1 when sat_value would clip x.
  function automatic logic sat_flag(input wide_t x, input int out_w);
    return (x > sat_max(out_w)) || (x < sat_min(out_w));
  endfunction

endpackage

// File: rtl/fixed_act_pipe_reg.sv
// One valid/ready register slice.
// The slice loads whenever it is empty or its current beat leaves in the same
// cycle, so a chain of slices sustains one beat per cycle.
module fixed_act_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Capture a new beat when there is room. Data is kept as-is when the
  // incoming valid is low, so idle input lines never reach the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/fixed_act_requant.sv
// Fixed-point requantiser placed ahead of the LUT activation stages.
// Each lane is rounded half-up and then saturated to the output format.
// The datapath is a two-deep valid/ready pipeline:
//   - stage 1 holds the rounded sums;
//   - stage 2 holds the saturated outputs.
// Optional build macro FIXED_ACT_REQUANT_SAT_CNT_EN adds a sticky 16-bit
// count of saturated lanes and its clear input.
module fixed_act_requant
  import fixed_act_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0       = 32,
  parameter int DATA_IN_0_PRECISION_1       = 16,
  parameter int DATA_OUT_0_PRECISION_0      = 8,
  parameter int DATA_OUT_0_PRECISION_1      = 4,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
  parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic data_in_0_valid,
  output logic data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic data_out_0_valid,
  input  logic data_out_0_ready
`ifdef FIXED_ACT_REQUANT_SAT_CNT_EN
  ,
  input  logic        sat_count_clear,
  output logic [15:0] sat_count
`endif
);

  localparam int N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int IN_W  = DATA_IN_0_PRECISION_0;
  localparam int OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int S     = calc_shift(DATA_IN_0_PRECISION_1, DATA_OUT_0_PRECISION_1);

  // The rounding add happens one bit wider than the input, so the shifted
  // result always fits in IN_W+1 bits.
  localparam int RW    = IN_W + 1;
  localparam int S1_W  = N * RW;

`ifdef FIXED_ACT_REQUANT_SAT_CNT_EN
  // Per-lane saturation flags ride along in stage 2 with their data.
  localparam int S2_W  = N * OUT_W + N;
`else
  localparam int S2_W  = N * OUT_W;
`endif

  // Reject configurations where the output keeps more fraction bits than
  // the input provides.
  if (S < 0) begin : g_bad_frac
    $error("fixed_act_requant: output fraction bits exceed input fraction bits");
  end

  logic [S1_W-1:0]  w_s1_din;
  logic [S1_W-1:0]  w_s1_q;
  logic             w_s1_valid;
  logic             w_s2_ready;
  logic [N*OUT_W-1:0] w_sat_data;
  logic [S2_W-1:0]  w_s2_din;
  logic [S2_W-1:0]  w_s2_q;

  // Stage 1 input: round each lane.
  for (genvar gi = 0; gi < N; gi++) begin : g_round
    assign w_s1_din[gi*RW +: RW] =
      RW'(round_lane(wide_t'($signed(data_in_0[gi*IN_W +: IN_W])), S));
  end

  fixed_act_pipe_reg #(
    .WIDTH (S1_W)
  ) u_stage1 (
    .clk     (clk),
    .rst_n   (rst),
    .i_valid (data_in_0_valid),
    .o_ready (data_in_0_ready),
    .i_data  (w_s1_din),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_q)
  );

  // Stage 2 input: saturate each rounded lane.
  for (genvar gi = 0; gi < N; gi++) begin : g_sat
    assign w_sat_data[gi*OUT_W +: OUT_W] =
      OUT_W'(sat_value(wide_t'($signed(w_s1_q[gi*RW +: RW])), OUT_W));
  end

`ifdef FIXED_ACT_REQUANT_SAT_CNT_EN
  logic [N-1:0] w_sat_flags;

  for (genvar gi = 0; gi < N; gi++) begin : g_flag
    assign w_sat_flags[gi] = sat_flag(wide_t'($signed(w_s1_q[gi*RW +: RW])), OUT_W);
  end

  assign w_s2_din = {w_sat_flags, w_sat_data};
`else
  assign w_s2_din = w_sat_data;
`endif

  fixed_act_pipe_reg #(
    .WIDTH (S2_W)
  ) u_stage2 (
    .clk     (clk),
    .rst_n   (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_din),
    .o_valid (data_out_0_valid),
    .i_ready (data_out_0_ready),
    .o_data  (w_s2_q)
  );

  assign data_out_0 = w_s2_q[N*OUT_W-1:0];

`ifdef FIXED_ACT_REQUANT_SAT_CNT_EN
  logic [15:0] r_sat_count;
  logic [15:0] w_sat_lanes;
  logic [16:0] w_sat_sum;

  // Count the saturated lanes in the beat presented at the output.
  always_comb begin
    w_sat_lanes = '0;
    for (int i = 0; i < N; i++) begin
      w_sat_lanes = w_sat_lanes + 16'(w_s2_q[N*OUT_W + i]);
    end
  end

  assign w_sat_sum = {1'b0, r_sat_count} + {1'b0, w_sat_lanes};

  // Accumulate on each output transfer and stick at all-ones.
  // A clear in the same cycle takes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat_count <= '0;
    end else if (sat_count_clear) begin
      r_sat_count <= '0;
    end else if (data_out_0_valid && data_out_0_ready) begin
      r_sat_count <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end
  end

  assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_fixed_act_requant.sv
// Scoreboard bench for fixed_act_requant in its default configuration
// (Q16.16 in, Q4.4 out, one lane).
// Build with FIXED_ACT_REQUANT_SAT_CNT_EN defined to also exercise the
// saturation counter.
module tb_fixed_act_requant;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] data_in_0 = '0;
  logic        data_in_0_valid = 1'b0;
  logic        data_in_0_ready;
  logic [7:0]  data_out_0;
  logic        data_out_0_valid;
  logic        data_out_0_ready = 1'b1;
`ifdef FIXED_ACT_REQUANT_SAT_CNT_EN
  logic        sat_count_clear = 1'b0;
  logic [15:0] sat_count;
`endif

  fixed_act_requant dut (
    .clk              (clk),
    .rst              (rst),
    .data_in_0        (data_in_0),
    .data_in_0_valid  (data_in_0_valid),
    .data_in_0_ready  (data_in_0_ready),
    .data_out_0       (data_out_0),
    .data_out_0_valid (data_out_0_valid),
    .data_out_0_ready (data_out_0_ready)
`ifdef FIXED_ACT_REQUANT_SAT_CNT_EN
    ,
    .sat_count_clear  (sat_count_clear),
    .sat_count        (sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         tcyc;
    bit         chk_lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   rand_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Independent reference: Q16.16 -> Q4.4, round half-up, saturate to 8 bits.
  function automatic logic [7:0] model(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v + 64'sd2048) >>> 12;
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
    return v[7:0];
  endfunction

  // Offer one beat for up to max_cyc cycles.
  // The expected result is queued at the cycle the handshake completes.
  task automatic offer(input logic [31:0] x, input logic [7:0] exp, input bit lat,
                       input int max_cyc, output bit ok);
    ok = 1'b0;
    data_in_0 = x;
    data_in_0_valid = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (data_in_0_ready) begin
        sb_q.push_back('{exp, cyc, lat});
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    data_in_0_valid = 1'b0;
    data_in_0 = 32'hDEAD_BEEF;
  endtask

  task automatic send(input logic [31:0] x, input logic [7:0] exp, input bit lat);
    bit ok;
    offer(x, exp, lat, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no ready expected accept of %h", x);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
  endtask

  // Monitor: pop and compare on every output transfer. Also verify that a
  // stalled output holds its valid and data.
  initial begin
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(data_out_0_valid), 32'd1);
          check("hold_data", 32'(data_out_0), 32'(prev_data));
        end
        if (data_out_0_valid && data_out_0_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h expected no beat", data_out_0);
          end else begin
            e = sb_q.pop_front();
            check("data_out", 32'(data_out_0), 32'(e.data));
            if (e.chk_lat) check("latency", 32'(cyc - e.tcyc), 32'd2);
          end
        end
        prev_stall = data_out_0_valid && !data_out_0_ready;
        prev_data  = data_out_0;
      end
    end
  end

  // Random backpressure driver, active only during the streaming phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_en) data_out_0_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          ok;
    int          n_acc;
    logic [31:0] r;
    logic [31:0] x;

    // Hold reset across a few edges and check the idle state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(data_out_0_valid), 32'd0);
    check("rst_data_out", 32'(data_out_0), 32'd0);
    check("rst_in_ready", 32'(data_in_0_ready), 32'd1);
`ifdef FIXED_ACT_REQUANT_SAT_CNT_EN
    check("rst_sat_count", 32'(sat_count), 32'd0);
`endif
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // 1.5 -> 0x18, with latency checked.
    send(32'h0001_8000, 8'h18, 1'b1);
    wait_drain(20);

    // Exact-half rounding cases.
    send(32'h0000_0800, 8'h01, 1'b0);
    send(32'hFFFF_F800, 8'h00, 1'b0);
    send(32'hFFFF_F7FF, 8'hFF, 1'b0);
    wait_drain(20);

    // Saturation cases.
    send(32'h0010_0000, 8'h7F, 1'b0);
    send(32'hFFF0_0000, 8'h80, 1'b0);
    wait_drain(20);
`ifdef FIXED_ACT_REQUANT_SAT_CNT_EN
    @(posedge clk); #1;
    check("sat_count", 32'(sat_count), 32'd2);
    sat_count_clear = 1'b1;
    @(posedge clk); #1;
    sat_count_clear = 1'b0;
    check("sat_count_clr", 32'(sat_count), 32'd0);
`endif

    // Backpressure: output stalled, three beats offered.
    data_out_0_ready = 1'b0;
    n_acc = 0;
    offer(32'h0001_8000, 8'h18, 1'b0, 5, ok);
    n_acc += int'(ok);
    offer(32'h0002_8000, 8'h28, 1'b0, 4, ok);
    n_acc += int'(ok);
    data_in_0 = 32'hFFFE_8000;
    data_in_0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(data_in_0_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("bp_accepted", 32'(n_acc), 32'd2);
    data_out_0_ready = 1'b1;
    offer(32'hFFFE_8000, 8'hE8, 1'b0, 5, ok);
    check("bp_third_accept", 32'(ok), 32'd1);
    wait_drain(20);

    // Reset asserted with two beats in flight.
    send(32'h0003_0000, 8'h30, 1'b0);
    send(32'h0004_0000, 8'h40, 1'b0);
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(data_out_0_valid), 32'd0);
    check("mid_rst_data_out", 32'(data_out_0), 32'd0);
    check("mid_rst_in_ready", 32'(data_in_0_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    offer(32'h0001_8000, 8'h18, 1'b1, 1, ok);
    check("post_rst_accept", 32'(ok), 32'd1);
    wait_drain(20);
    repeat (4) @(posedge clk);
    #1;

    // Streaming: 100 beats under random backpressure, checked against the model.
    rand_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      r = $urandom;
      if ($urandom_range(0, 3) != 0) x = {{13{r[18]}}, r[18:0]};
      else x = r;
      send(x, model(x), 1'b0);
    end
    rand_en = 1'b0;
    @(posedge clk); #1;
    data_out_0_ready = 1'b1;
    wait_drain(200);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
